dvsd_pe_wb_ctrl: RTL and testbench

//  Wishbone slave control/status front-end that feeds the 8-to-3 priority encoder in user_project_wrapper.

---
 rtl/dvsd_pe_wb_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dvsd_pe_wb_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvsd_pe_wb_ctrl.sv
// Wishbone control/status front-end for the 8-to-3 priority encoder.
// Holds the request vector, sequences an encode, and captures code/gs/eo with a done flag and count.
module dvsd_pe_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned PE_LAT    = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  pe_in_o,
    output logic        pe_en_o,
    input  logic [2:0]  pe_code_i,
    input  logic        pe_gs_i,
    input  logic        pe_eo_i,
    output logic        irq_o
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_CAPTURE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             ack_q, ack_d;
    logic             irq_en_q, irq_en_d;
    logic             auto_q, auto_d;
    logic [7:0]       req_q, req_d;
    logic [7:0]       pe_in_q, pe_in_d;
    logic             pe_en_q, pe_en_d;
    logic [2:0]       code_q, code_d;
    logic             gs_q, gs_d;
    logic             eo_q, eo_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;

    logic             hit, wr, busy, start;
    logic [1:0]       off;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign hit  = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr   = ack_q & hit & wbs_we_i;
    assign off  = wbs_adr_i[3:2];
    assign busy = (state_q != S_IDLE);

    assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:9], wbs_adr_i[1:0]};

    always_comb begin
        ack_d    = hit & ~ack_q;
        state_d  = state_q;
        wait_d   = wait_q;
        irq_en_d = irq_en_q;
        auto_d   = auto_q;
        req_d    = req_q;
        pe_in_d  = pe_in_q;
        pe_en_d  = pe_en_q;
        code_d   = code_q;
        gs_d     = gs_q;
        eo_d     = eo_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        irq_d    = irq_en_q & done_q;
        start    = 1'b0;

        // Register writes land in the ack cycle, before the FSM so a capture can override them.
        if (wr) begin
            case (off)
                2'd0: if (wbs_sel_i[0]) begin
                    irq_en_d = wbs_dat_i[1];
                    auto_d   = wbs_dat_i[2];
                    start    = wbs_dat_i[0];
                end
                2'd1: if (wbs_sel_i[0] && !busy) begin
                    req_d = wbs_dat_i[7:0];
                    start = auto_q;
                end
                2'd2: if (wbs_sel_i[1] && wbs_dat_i[8]) done_d = 1'b0;
                default: cnt_d = '0;
            endcase
        end

        case (state_q)
            S_IDLE: if (start) begin
                pe_in_d = req_d;
                pe_en_d = 1'b1;
                state_d = S_DRIVE;
            end
            S_DRIVE: begin
                wait_d  = 4'(PE_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q - 4'd1;
                // Sample on the edge the counter reaches zero; the encoder has settled by then.
                if (wait_q == 4'd1) begin
                    state_d = S_CAPTURE;
                    code_d  = pe_code_i;
                    gs_d    = pe_gs_i;
                    eo_d    = pe_eo_i;
                    done_d  = 1'b1;
                    if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_W'(1);
                end
            end
            default: begin
                pe_en_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        case (off)
            2'd0:    rdata = {23'd0, busy, 5'd0, auto_q, irq_en_q, 1'b0};
            2'd1:    rdata[7:0] = req_q;
            2'd2:    rdata = {23'd0, done_q, 2'd0, eo_q, gs_q, 1'b0, code_q};
            default: rdata[CNT_W-1:0] = cnt_q;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            ack_q    <= 1'b0;
            irq_en_q <= 1'b0;
            auto_q   <= 1'b0;
            req_q    <= '0;
            pe_in_q  <= '0;
            pe_en_q  <= 1'b0;
            code_q   <= '0;
            gs_q     <= 1'b0;
            eo_q     <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            ack_q    <= ack_d;
            irq_en_q <= irq_en_d;
            auto_q   <= auto_d;
            req_q    <= req_d;
            pe_in_q  <= pe_in_d;
            pe_en_q  <= pe_en_d;
            code_q   <= code_d;
            gs_q     <= gs_d;
            eo_q     <= eo_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = ack_q ? rdata : 32'd0;
    assign pe_in_o   = pe_in_q;
    assign pe_en_o   = pe_en_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_dvsd_pe_wb_ctrl.sv
// Bench for dvsd_pe_wb_ctrl: bus-level transactions checked against a register-level model,
// with a behavioural priority encoder attached to the pe_* pins.
`timescale 1ns/1ps
module tb_dvsd_pe_wb_ctrl;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          PE_LAT  = 1;
    localparam int          CNT_W   = 4;
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr, dat_o;
    logic        ack;
    logic [7:0]  pe_in;
    logic        pe_en;
    logic [2:0]  pe_code;
    logic        pe_gs, pe_eo, irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dvsd_pe_wb_ctrl #(.BASE_ADDR(BASE), .PE_LAT(PE_LAT), .CNT_W(CNT_W)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .pe_in_o(pe_in), .pe_en_o(pe_en), .pe_code_i(pe_code),
        .pe_gs_i(pe_gs), .pe_eo_i(pe_eo), .irq_o(irq)
    );

    // 8-to-3 priority encoder: highest set input wins; result appears PE_LAT cycles later.
    function automatic logic [4:0] enc_f(input logic [7:0] v, input logic en);
        logic [2:0] c;
        c = 3'd0;
        if (!en) return 5'd0;
        for (int i = 0; i < 8; i++) if (v[i]) c = 3'(i);
        return {c, |v, ~|v};
    endfunction

    logic [4:0] enc_pipe [PE_LAT];
    always @(posedge clk) begin
        enc_pipe[0] <= enc_f(pe_in, pe_en);
        for (int i = 1; i < PE_LAT; i++) enc_pipe[i] <= enc_pipe[i-1];
    end
    assign {pe_code, pe_gs, pe_eo} = enc_pipe[PE_LAT-1];

    // Register-level reference model.
    logic [7:0] m_req, m_pe_in;
    logic       m_irq_en, m_auto, m_done, m_busy, m_gs, m_eo;
    logic [2:0] m_code;
    int         m_count;

    task automatic m_reset();
        m_req = 0; m_pe_in = 0; m_irq_en = 0; m_auto = 0; m_done = 0;
        m_busy = 0; m_gs = 0; m_eo = 0; m_code = 0; m_count = 0;
    endtask

    task automatic m_write(input logic [1:0] off, input logic [3:0] s, input logic [31:0] d);
        logic go;
        go = 1'b0;
        case (off)
            2'd0: if (s[0]) begin go = d[0]; m_irq_en = d[1]; m_auto = d[2]; end
            2'd1: if (s[0] && !m_busy) begin m_req = d[7:0]; go = m_auto; end
            2'd2: if (s[1] && d[8]) m_done = 1'b0;
            default: m_count = 0;
        endcase
        if (go && !m_busy) begin m_busy = 1'b1; m_pe_in = m_req; end
    endtask

    task automatic m_complete();
        if (m_busy) begin
            {m_code, m_gs, m_eo} = enc_f(m_pe_in, 1'b1);
            m_done = 1'b1;
            if (m_count < int'(CNT_MAX)) m_count++;
            m_busy = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return {23'd0, m_busy, 5'd0, m_auto, m_irq_en, 1'b0};
            2'd1:    return {24'd0, m_req};
            2'd2:    return {23'd0, m_done, 2'd0, m_eo, m_gs, 1'b0, m_code};
            default: return 32'(m_count);
        endcase
    endfunction

    // One classic Wishbone access; holds the request through the ack cycle, bounded wait.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int lat,
                        output logic ack_after);
        stb = 1; cyc = 1; we = w; adr = a; sel = s; dat_i = d;
        lat = 0; rd = 0;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin lat = i; rd = dat_o; end
        end
        if (lat != 0) begin @(posedge clk); #1; end
        ack_after = ack;
        stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
    endtask

    task automatic wr(input logic [1:0] off, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd; int lat; logic ack2;
        xfer(1'b1, BASE | (32'(off) << 2), s, d, rd, lat, ack2);
        m_write(off, s, d);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL wr_ack_lat off=%0d got %0d want 1", off, lat); end
        n_checks++;
        if (ack2 !== 1'b0) begin n_fail++; $display("FAIL wr_ack_width off=%0d got %b want 0", off, ack2); end
    endtask

    task automatic rd_chk(input logic [1:0] off, input string nm);
        logic [31:0] rd, exp; int lat; logic ack2;
        xfer(1'b0, BASE | (32'(off) << 2), 4'hF, 32'd0, rd, lat, ack2);
        exp = m_read(off);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL %s_ack_lat got %0d want 1", nm, lat); end
        n_checks++;
        if (rd !== exp) begin n_fail++; $display("FAIL %s_data got %h want %h", nm, rd, exp); end
        n_checks++;
        if (ack2 !== 1'b0 || dat_o !== 32'd0) begin
            n_fail++; $display("FAIL %s_idle_bus got ack=%b dat=%h want 0/0", nm, ack2, dat_o);
        end
        $display("read %s off=%0d data=%h exp=%h", nm, off, rd, exp);
    endtask

    task automatic wait_idle();
        repeat (PE_LAT + 4) @(posedge clk);
        #1;
        m_complete();
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if ({ack, pe_en, irq, pe_in, dat_o} !== 43'd0) begin
            n_fail++; $display("FAIL reset_outputs got ack=%b en=%b irq=%b in=%h dat=%h want all 0",
                               ack, pe_en, irq, pe_in, dat_o);
        end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        m_reset();
        for (int i = 0; i < 4; i++) rd_chk(2'(i), "reset_rd");
    endtask

    task automatic test_encode();
        wr(2'd1, 4'h1, 32'h52);
        wr(2'd0, 4'h1, 32'h1);
        n_checks++;
        if (pe_in !== 8'h52 || pe_en !== 1'b1) begin
            n_fail++; $display("FAIL enc_drive got in=%h en=%b want 52/1", pe_in, pe_en);
        end
        wait_idle();
        rd_chk(2'd2, "enc_result");
        rd_chk(2'd3, "enc_count");
        n_checks++;
        if (pe_en !== 1'b0 || pe_in !== 8'h52) begin
            n_fail++; $display("FAIL enc_release got in=%h en=%b want 52/0", pe_in, pe_en);
        end
    endtask

    task automatic test_latency();
        int k;
        wr(2'd2, 4'h2, 32'h100);
        @(posedge clk); #1;
        wr(2'd0, 4'h1, 32'h3);
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) k = i;
        end
        m_complete();
        // irq is one register behind DONE; DONE lands PE_LAT+2 edges after the ack edge.
        n_checks++;
        if (k != PE_LAT + 2) begin n_fail++; $display("FAIL done_latency got %0d want %0d", k, PE_LAT + 2); end
        wait_idle();
        rd_chk(2'd0, "lat_ctrl");
    endtask

    task automatic test_auto_irq();
        wr(2'd0, 4'h1, 32'h6);
        wr(2'd1, 4'h1, 32'h0);
        wait_idle();
        rd_chk(2'd2, "auto_result");
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL auto_irq got %b want 1", irq); end
        wr(2'd2, 4'h2, 32'h100);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_hold got %b want 1", irq); end
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_fall got %b want 0", irq); end
        rd_chk(2'd2, "w1c_result");
    endtask

    task automatic test_busy();
        wr(2'd0, 4'h1, 32'h0);
        wr(2'd1, 4'h1, 32'h3C);
        wr(2'd0, 4'h1, 32'h1);
        wr(2'd1, 4'h1, 32'hFF);
        n_checks++;
        if (pe_in !== 8'h3C) begin n_fail++; $display("FAIL busy_pe_in got %h want 3c", pe_in); end
        wait_idle();
        rd_chk(2'd1, "busy_req");
        rd_chk(2'd2, "busy_result");
        wr(2'd0, 4'h1, 32'h1);
        rd_chk(2'd0, "busy_flag");
        wait_idle();
    endtask

    task automatic test_conflicts();
        wr(2'd0, 4'h1, 32'h1);
        wr(2'd3, 4'($urandom_range(0, 15)), $urandom);
        m_complete();
        wait_idle();
        rd_chk(2'd3, "cnt_clr_vs_inc");
        wr(2'd0, 4'h1, 32'h1);
        wr(2'd2, 4'h2, 32'h100);
        m_complete();
        wait_idle();
        rd_chk(2'd2, "done_w1c_vs_set");
    endtask

    task automatic test_miss();
        logic [31:0] rd, a; int lat; logic ack2;
        xfer(1'b1, BASE + 32'h10, 4'b0001, 32'h7, rd, lat, ack2);
        n_checks++;
        if (lat !== 0) begin n_fail++; $display("FAIL miss_ack got lat %0d want none", lat); end
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            if (a[31:4] == BASE[31:4]) a[31] = ~a[31];
            xfer(1'b1, a, 4'hF, $urandom, rd, lat, ack2);
            n_checks++;
            if (lat !== 0) begin n_fail++; $display("FAIL miss_rand_ack adr=%h got lat %0d want none", a, lat); end
        end
        for (int i = 0; i < 4; i++) rd_chk(2'(i), "miss_rd");
    endtask

    task automatic test_saturate();
        logic [31:0] rd; int lat; logic ack2;
        wr(2'd3, 4'h1, 32'h0);
        wr(2'd0, 4'h1, 32'h4);
        for (int i = 0; i < int'(CNT_MAX) + 2; i++) begin
            wr(2'd1, 4'h1, $urandom);
            wait_idle();
        end
        xfer(1'b0, BASE | 32'hC, 4'hF, 32'd0, rd, lat, ack2);
        n_checks++;
        if (rd !== CNT_MAX) begin n_fail++; $display("FAIL count_saturate got %h want %h", rd, CNT_MAX); end
        rd_chk(2'd2, "sat_result");
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            wr(2'd0, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 7)));
            wr(2'd1, 4'($urandom_range(0, 15)), $urandom);
            wait_idle();
            if ($urandom_range(0, 1) == 1) begin
                wr(2'd2, 4'($urandom_range(0, 15)), $urandom);
                @(posedge clk); #1;
            end
            n_checks++;
            if (irq !== (m_irq_en & m_done)) begin
                n_fail++; $display("FAIL rand_irq it=%0d got %b want %b", it, irq, m_irq_en & m_done);
            end
            rd_chk(2'd2, "rand_result");
            rd_chk(2'($urandom_range(0, 3)), "rand_rd");
        end
    endtask

    task automatic test_reset_mid();
        wr(2'd0, 4'h1, 32'h3);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        n_checks++;
        if (pe_en !== 1'b0 || irq !== 1'b0 || pe_in !== 8'd0) begin
            n_fail++; $display("FAIL rst_mid_outputs got en=%b irq=%b in=%h want 0/0/00", pe_en, irq, pe_in);
        end
        m_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        rd_chk(2'd0, "rst_mid_ctrl");
        rd_chk(2'd2, "rst_mid_result");
        rd_chk(2'd3, "rst_mid_count");
    endtask

    initial begin
        stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0; rst_n = 0;
        m_reset();
        test_reset();
        test_encode();
        test_latency();
        test_auto_irq();
        test_busy();
        test_conflicts();
        test_miss();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
